// File: rtl/apb_rr_pkg.sv
// Shared types and constants for the round-robin APB master.
// Controller state encoding and the register map of the APB register slave.
package apb_rr_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StErr    = 2'd3
    } apb_state_e;

    localparam logic [31:0] CNTRL_ADDR = 32'h0000_0000;
    localparam logic [31:0] REG1_ADDR  = 32'h0000_0004;
    localparam logic [31:0] REG2_ADDR  = 32'h0000_0008;
    localparam logic [31:0] REG3_ADDR  = 32'h0000_000C;
    localparam logic [31:0] REG4_ADDR  = 32'h0000_0010;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned  NUM_REQ = 2,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin arbitrating APB master.
// Shares one zero-wait-state APB register slave between NUM_REQ requesters.
// Optional: define APB_RR_ADDR_CHECK_EN to reject commands outside the register
// map with an error response instead of an APB transfer.
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 2,
    parameter int unsigned  ADDR_W  = 32,
    parameter int unsigned  DATA_W  = 32,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [DATA_W-1:0]         prdata
);

    apb_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               addr_ok;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (state_q == StIdle),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign sel_addr  = req_addr[32'(gnt_idx) * ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[32'(gnt_idx) * DATA_W +: DATA_W];

`ifdef APB_RR_ADDR_CHECK_EN
    logic rsp_err_q, rsp_err_d;

    assign addr_ok = (sel_addr == ADDR_W'(CNTRL_ADDR)) || (sel_addr == ADDR_W'(REG1_ADDR)) ||
                     (sel_addr == ADDR_W'(REG2_ADDR))  || (sel_addr == ADDR_W'(REG3_ADDR)) ||
                     (sel_addr == ADDR_W'(REG4_ADDR));
    assign rsp_err = rsp_err_q;
`else
    assign addr_ok = 1'b1;
    assign rsp_err = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE/SETUP/ACCESS sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        rsp_rdata_d = '0;
`ifdef APB_RR_ADDR_CHECK_EN
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                pwrite_d = 1'b0;
                if (|gnt) begin
                    id_d  = gnt_idx;
                    ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                    if (addr_ok) begin
                        state_d  = StSetup;
                        psel_d   = 1'b1;
                        paddr_d  = sel_addr;
                        pwdata_d = sel_wdata;
                        pwrite_d = req_write[gnt_idx];
                    end
`ifdef APB_RR_ADDR_CHECK_EN
                    else begin
                        state_d = StErr;
                    end
`endif
                end
            end
            StSetup: begin
                state_d   = StAccess;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            StAccess: begin
                // Slave has no pready: ACCESS always completes in one cycle.
                state_d     = StIdle;
                pwrite_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_rdata_d = pwrite_q ? '0 : prdata;
            end
`ifdef APB_RR_ADDR_CHECK_EN
            StErr: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_err_d   = 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, captured command, APB outputs and response registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ptr_q       <= '0;
            id_q        <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_RR_ADDR_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_RR_ADDR_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed testbench for apb_rr_master with two requesters and a small
// register-slave model. Error-response case runs when APB_RR_ADDR_CHECK_EN is defined.
module tb_apb_rr_master;
    import apb_rr_pkg::*;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable;

    int n_checks = 0;
    int n_fail   = 0;

    apb_rr_master #(
        .NUM_REQ (2),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata)
    );

    always #5 pclk = ~pclk;

    // Zero-wait-state register slave: five words at 0x0..0x10.
    logic [31:0] mem [8] = '{default: 32'h0};
    always_comb prdata = mem[paddr[4:2]];
    always @(posedge pclk) begin
        if (psel && penable && pwrite) mem[paddr[4:2]] <= pwdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One full command from requester id, checking every phase.
    task automatic do_cmd(input int id, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        int n;
        req_valid                = '0;
        req_valid[id]            = 1'b1;
        req_write[id]            = wr;
        req_addr[id*32 +: 32]    = addr;
        req_wdata[id*32 +: 32]   = wd;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check_eq("cmd_ready", req_ready, 64'(2'b01 << id));
        tick();
        req_valid = '0;
        check_eq("setup_psel", psel, 1);
        check_eq("setup_penable", penable, 0);
        check_eq("setup_paddr", paddr, addr);
        check_eq("setup_pwrite", pwrite, wr);
        if (wr) check_eq("setup_pwdata", pwdata, wd);
        tick();
        check_eq("access_psel", psel, 1);
        check_eq("access_penable", penable, 1);
        check_eq("access_paddr", paddr, addr);
        check_eq("access_rsp_valid", rsp_valid, 0);
        tick();
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_id", rsp_id, id);
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("rsp_err", rsp_err, 0);
        check_eq("idle_psel", psel, 0);
        check_eq("idle_penable", penable, 0);
        check_eq("idle_pwrite", pwrite, 0);
        tick();
        check_eq("rsp_pulse_end", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, k1, ng, cyc, last, gi;
        logic [1:0] g;

        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) tick();
        check_eq("rst_psel", psel, 0);
        check_eq("rst_penable", penable, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_paddr", paddr, 0);
        presetn = 1'b1;

        // Idle: nothing requested for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle10_psel", psel, 0);
            check_eq("idle10_penable", penable, 0);
            check_eq("idle10_ready", req_ready, 0);
        end

        // Single write, cntrl write, read-backs through each requester.
        do_cmd(0, 1'b1, REG1_ADDR, 32'hDEAD_BEEF, 32'h0);
        do_cmd(1, 1'b1, CNTRL_ADDR, 32'h0000_000F, 32'h0);
        do_cmd(0, 1'b0, REG1_ADDR, 32'h0, 32'hDEAD_BEEF);
        do_cmd(1, 1'b0, CNTRL_ADDR, 32'h0, 32'h0000_000F);

        // Contention: both requesters hold valid for four writes each.
        req_write          = 2'b11;
        req_addr[31:0]     = REG2_ADDR;
        req_addr[63:32]    = REG3_ADDR;
        req_wdata[31:0]    = 32'hA000_0000;
        req_wdata[63:32]   = 32'hB000_0000;
        req_valid          = 2'b11;
        k0 = 0; k1 = 0; ng = 0; cyc = 0; last = 0;
        #1;
        while ((k0 < 4 || k1 < 4) && cyc < 100) begin
            g = req_ready;
            tick();
            cyc++;
            if (g != 2'b00) begin
                check_eq("cont_onehot", $countones(g), 1);
                gi = g[1] ? 1 : 0;
                check_eq("cont_order", gi, ng % 2);
                if (ng > 0) check_eq("cont_spacing", cyc - last, 3);
                last = cyc;
                ng++;
                if (gi == 0) begin
                    k0++;
                    if (k0 == 4) req_valid[0] = 1'b0;
                    else req_wdata[31:0] = 32'hA000_0000 + k0;
                end else begin
                    k1++;
                    if (k1 == 4) req_valid[1] = 1'b0;
                    else req_wdata[63:32] = 32'hB000_0000 + k1;
                end
            end
        end
        check_eq("cont_grants", ng, 8);
        repeat (3) tick();
        do_cmd(0, 1'b0, REG2_ADDR, 32'h0, 32'hA000_0003);
        do_cmd(1, 1'b0, REG3_ADDR, 32'h0, 32'hB000_0003);

        // Reset during ACCESS: abandoned, no response, pointer back to 0.
        req_valid        = 2'b01;
        req_write        = 2'b01;
        req_addr[31:0]   = REG4_ADDR;
        req_wdata[31:0]  = 32'h0000_1234;
        #1;
        check_eq("mid_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        check_eq("mid_access", penable, 1);
        presetn = 1'b0;
        #1;
        check_eq("mid_rst_psel", psel, 0);
        check_eq("mid_rst_penable", penable, 0);
        check_eq("mid_rst_rsp", rsp_valid, 0);
        tick();
        tick();
        presetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("post_rst_no_rsp", rsp_valid, 0);
        end
        req_write       = 2'b00;
        req_addr[31:0]  = REG2_ADDR;
        req_addr[63:32] = REG3_ADDR;
        req_valid       = 2'b11;
        #1;
        check_eq("post_rst_ptr", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        tick();
        check_eq("post_rst_rsp_valid", rsp_valid, 1);
        check_eq("post_rst_rsp_id", rsp_id, 0);
        check_eq("post_rst_rsp_rdata", rsp_rdata, 32'hA000_0003);
        tick();
        do_cmd(1, 1'b0, REG4_ADDR, 32'h0, 32'h0);

`ifdef APB_RR_ADDR_CHECK_EN
        // Out-of-map address: error response, no APB activity.
        req_valid       = 2'b01;
        req_write       = 2'b00;
        req_addr[31:0]  = 32'h0000_0014;
        #1;
        check_eq("err_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        check_eq("err_psel", psel, 0);
        check_eq("err_no_rsp_yet", rsp_valid, 0);
        tick();
        check_eq("err_rsp_valid", rsp_valid, 1);
        check_eq("err_rsp_err", rsp_err, 1);
        check_eq("err_rsp_rdata", rsp_rdata, 0);
        check_eq("err_rsp_id", rsp_id, 0);
        check_eq("err_psel2", psel, 0);
        tick();
        check_eq("err_pulse_end", rsp_valid, 0);
        do_cmd(1, 1'b0, REG2_ADDR, 32'h0, 32'hA000_0003);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin arbitrating APB master that shares the single APB register slave (cntrl at 0x0, reg1..reg4 at 0x4..0x10) between NUM_REQ internal requesters.
- Each requester issues one read or write command over a valid/ready handshake. The block sequences the APB IDLE/SETUP/ACCESS phases and returns a one-cycle response tagged with the requester index.
- Sits between firmware-side agents (config loader, debug port) and the APB register slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.

Ports:
- pclk  in  1  clock.
- presetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accepted (one-hot pulse).
- req_write  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing.
- rsp_valid  out  1  response pulse.
- rsp_id  out  $clog2(NUM_REQ) (min 1)  index of the responding requester.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  address error (see Optional Feature).
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  DATA_W  APB read data.

Behaviour:
- Reset (async, presetn=0):
  - All outputs 0; FSM = IDLE; round-robin pointer = 0.
  - An in-flight transfer is abandoned: psel/penable drop immediately and no response is issued.
- FSM states IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE, any req_valid set:
  - Winner = first set bit searching from pointer upward, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in that cycle only; the handshake completes on that edge.
  - Command and winner id are captured into internal registers; next state = SETUP; pointer <= (winner+1) mod NUM_REQ.
- IDLE, no req_valid: req_ready=0; stay in IDLE; pointer unchanged.
- SETUP: psel=1, penable=0, with paddr/pwrite/pwdata from the captured command. Next state = ACCESS.
- ACCESS: psel=1, penable=1, APB outputs unchanged. The slave has no pready, so the transfer is fixed at zero wait states. Next state = IDLE.
- On the ACCESS->IDLE edge:
  - Register rsp_valid=1, rsp_id, and rsp_rdata (prdata sampled on that edge for reads, 0 for writes).
  - rsp_valid lasts exactly one cycle, coincident with the next IDLE.
- In the first IDLE after ACCESS: psel=0, penable=0. paddr and pwdata hold their last values; pwrite=0, so the slave's read path is harmless.
- Throughput: one transfer per 3 cycles. Command acceptance to rsp_valid = 3 cycles.
- req_ready is never asserted outside IDLE. Requesters hold valid and command fields stable until ready.
- A new grant may occur in the same IDLE cycle in which rsp_valid is high.
- Fairness: with all requesters valid continuously, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- Simultaneous reset deassertion and req_valid: the first grant goes to the lowest valid index.

Optional Feature:
- Macro: APB_RR_ADDR_CHECK_EN.
- Defined:
  - A granted command whose address is not one of 0x0, 0x4, 0x8, 0xC, 0x10 skips SETUP/ACCESS; psel stays 0.
  - The FSM goes IDLE -> ERR (one cycle) -> IDLE, and rsp_valid pulses with rsp_err=1 and rsp_rdata=0 on the ERR->IDLE edge.
  - The pointer advances as for a normal grant.
- Undefined: no address check; ERR state absent; rsp_err tied to 0; every command produces an APB transfer.

Decomposition:
- Package apb_rr_pkg:
  - FSM state enum (IDLE, SETUP, ACCESS, ERR).
  - Register address constants CNTRL_ADDR=0x0, REG1_ADDR=0x4, REG2_ADDR=0x8, REG3_ADDR=0xC, REG4_ADDR=0x10, used by the address check and the bench.
- Sub-module rr_arbiter, parameterised on NUM_REQ:
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Pure combinational; the pointer register stays in the parent.

Test Plan:
- Single write: req0 writes 0xDEADBEEF to 0x4 -> psel=1/penable=0 one cycle then penable=1 one cycle with paddr=0x4, pwrite=1; rsp_valid id=0, rdata=0 three cycles after acceptance; later read of 0x4 returns 0xDEADBEEF.
- Read path: req1 reads 0x0 after cntrl was written 0xF -> rsp_id=1, rsp_rdata=0x0000000F.
- Contention: req0 and req1 both held valid for 4 commands each -> grant order 0,1,0,1,...; transfers spaced exactly 3 cycles; no requester gets two consecutive grants.
- Reset mid-transfer: assert presetn=0 during ACCESS -> psel/penable/rsp_valid fall immediately; after release, FSM is IDLE, pointer is 0, and no stale response appears.
- Idle behaviour: no req_valid for 10 cycles -> psel=0, penable=0, req_ready=0 throughout.
- With APB_RR_ADDR_CHECK_EN: req0 reads 0x14 -> no psel activity; rsp_valid with rsp_err=1 and rdata=0 two cycles after acceptance. A following valid read of 0x8 proceeds normally.
